mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in operand width, for the core's execute stage. One operation is accepted at a time and computed by radix-2 shift-add multiply or restoring division over XLEN cycles. `busy` stalls the core, and a one-cycle `done` returns the result to the write-back path.

---
 rtl/mdu_iter_if.sv | 32 +++
 rtl/mdu_iter.sv | 234 +++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the core execute stage and mdu_iter.
//
//   start   core -> mdu  request, accepted only while busy is low
//   funct3  core -> mdu  operation select (RV32M encoding), sampled with start
//   op_a    core -> mdu  rs1 value (multiplicand / dividend), sampled with start
//   op_b    core -> mdu  rs2 value (multiplier / divisor), sampled with start
//   flush   core -> mdu  abort of the in-flight operation
//   busy    mdu -> core  operation in flight, stage must hold
//   done    mdu -> core  one-cycle pulse, result valid
//   result  mdu -> core  registered result, held until the next done
interface mdu_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the execute stage.
//
// One operation in flight at a time. Multiply is radix-2 shift-add on a 2*XLEN product
// (acc:lo), divide is restoring division with the quotient shifted into lo and the
// remainder kept in acc. Both take XLEN CALC cycles; total latency from the accepting
// edge to done is XLEN+1 cycles.
//
// Ports:
//   clk  core clock, rising edge
//   rst  synchronous active-high reset (priority over flush and start)
//   bus  mdu_iter_if.slave: start/funct3/op_a/op_b/flush in, busy/done/result out
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, divide-by-zero, signed divide overflow and multiply by
//                     zero skip CALC and go straight to DONE (done one cycle after start,
//                     busy never asserted). Results are identical in both builds.
module mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;       // quotient / product sign
    logic            sa_q;        // dividend sign, i.e. remainder sign
    logic            div_zero_q;
    logic [XLEN-1:0] addend_q;    // multiplicand for MUL*, divisor for DIV*
    logic [XLEN-1:0] acc_q;       // product high half / partial remainder
    logic [XLEN-1:0] lo_q;        // multiplier bits / dividend bits -> quotient
    logic [XLEN-1:0] result_q, result_d;

    logic busy, done;
    logic accept, calc_last, early_hit;

    // ---------------------------------------------------------------------------------
    // Operand decode at issue time
    // ---------------------------------------------------------------------------------
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (bus.funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
        sa    = a_signed & bus.op_a[XLEN-1];
        sb    = b_signed & bus.op_b[XLEN-1];
        a_mag = sa ? -bus.op_a : bus.op_a;
        b_mag = sb ? -bus.op_b : bus.op_b;
    end

    // A flush in the same cycle drops the start.
    assign accept    = bus.start && !bus.flush && (state_q != StCalc);
    assign calc_last = (state_q == StCalc) && !bus.flush && (cnt_q == '0);

    // ---------------------------------------------------------------------------------
    // Early-out detection
    // ---------------------------------------------------------------------------------
`ifdef MDU_EARLY_OUT_EN
    logic [XLEN-1:0] early_res;
    logic            in_div0, in_ovf, in_mulz;

    always_comb begin
        in_div0   = bus.funct3[2] && (bus.op_b == '0);
        in_ovf    = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == MinNeg) &&
                    (bus.op_b == '1);
        in_mulz   = !bus.funct3[2] && ((bus.op_a == '0) || (bus.op_b == '0));
        early_hit = in_div0 || in_ovf || in_mulz;
        early_res = '0;
        if (in_div0) begin
            early_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (in_ovf) begin
            early_res = bus.funct3[1] ? '0 : bus.op_a;
        end
    end
`else
    assign early_hit = 1'b0;
`endif

    // ---------------------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = early_hit ? StDone : StCalc;
            end
            StCalc: begin
                if (bus.flush)          state_d = StIdle;
                else if (cnt_q == '0)   state_d = StDone;
            end
            StDone: begin
                if (accept) state_d = early_hit ? StDone : StCalc;
                else        state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StCalc:  busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;

    // ---------------------------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;   // (XLEN+1)-bit partial remainder
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] acc_nx, lo_nx;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, addend_q & {XLEN{lo_q[0]}}};
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, addend_q};
        if (op_q[2]) begin
            // Remainder stays below the divisor, so the sign bit of the difference is the
            // borrow; with a zero divisor the shifted value never reaches bit XLEN.
            if (div_diff[XLEN]) begin
                acc_nx = div_shift[XLEN-1:0];
                lo_nx  = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                acc_nx = div_diff[XLEN-1:0];
                lo_nx  = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nx = mul_sum[XLEN:1];
            lo_nx  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ---------------------------------------------------------------------------------
    // Final result, taken from the last step's outputs so it lands on the DONE edge
    // ---------------------------------------------------------------------------------
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;

    always_comb begin
        prod   = {acc_nx, lo_nx};
        prod_s = neg_q ? -prod : prod;
        // Zero divisor: the natural path already yields remainder = op_a, only the
        // quotient needs forcing. Signed overflow falls out naturally.
        quot_s = div_zero_q ? '1 : (neg_q ? -lo_nx : lo_nx);
        rem_s  = sa_q ? -acc_nx : acc_nx;
        unique case (op_q)
            3'd0:             final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quot_s;
            default:          final_res = rem_s;
        endcase
    end

    always_comb begin
        result_d = result_q;
        if (calc_last) result_d = final_res;
`ifdef MDU_EARLY_OUT_EN
        if (accept && early_hit) result_d = early_res;
`endif
    end

    // ---------------------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            sa_q       <= 1'b0;
            div_zero_q <= 1'b0;
            addend_q   <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q       <= bus.funct3;
                neg_q      <= sa ^ sb;
                sa_q       <= sa;
                div_zero_q <= bus.funct3[2] && (bus.op_b == '0);
                cnt_q      <= CntW'(XLEN - 1);
                acc_q      <= '0;
                if (bus.funct3[2]) begin
                    addend_q <= b_mag;
                    lo_q     <= a_mag;
                end else begin
                    addend_q <= a_mag;
                    lo_q     <= b_mag;
                end
            end else if (state_q == StCalc) begin
                acc_q <= acc_nx;
                lo_q  <= lo_nx;
                cnt_q <= cnt_q - CntW'(1);
            end
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

    localparam int unsigned XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam int SpecLat  = 1;
    localparam int SpecBusy = 0;
`else
    localparam int SpecLat  = 33;
    localparam int SpecBusy = 32;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(XLEN)) bus ();

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive a request at the current sample point; returns one cycle after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // lat = cycles from accepting edge to done (0 if not seen within the bound).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            busy_cnt += int'(bus.busy);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        issue(f, a, b);
        wait_done(lat, busy_cnt);
        res = bus.result;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL reset done: got %b expected 0", bus.done);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            failures++; $display("FAIL reset result: got %h expected 0", bus.result);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul;
        logic [2:0]  f[7]   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd3};
        logic [31:0] a[7]   = '{32'h7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b[7]   = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                32'h10, 32'h2, 32'hFFFFFFFF};
        logic [31:0] exp[7] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFF,
                                32'h23456780, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] res;
        int          lat, bc;
        for (int i = 0; i < 7; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bc);
            checks++;
            if (res !== exp[i]) begin
                failures++; $display("FAIL mul[%0d] result: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 33) begin
                failures++; $display("FAIL mul[%0d] latency: got %0d expected 33", i, lat);
            end
            checks++;
            if (bc != 32) begin
                failures++; $display("FAIL mul[%0d] busy cycles: got %0d expected 32", i, bc);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++; $display("FAIL mul[%0d] busy in done: got %b expected 0", i, bus.busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0) begin
                failures++; $display("FAIL mul[%0d] done width: got %b expected 0", i, bus.done);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f[8]   = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] a[8]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'h7, 32'h7, 32'd100, 32'd100};
        logic [31:0] b[8]   = '{32'h2, 32'h2, 32'h2, 32'h2,
                                32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7};
        logic [31:0] exp[8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1,
                                32'hFFFFFFFD, 32'h1, 32'hE, 32'h2};
        logic [31:0] res;
        int          lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bc);
            checks++;
            if (res !== exp[i]) begin
                failures++; $display("FAIL div[%0d] result: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 33) begin
                failures++; $display("FAIL div[%0d] latency: got %0d expected 33", i, lat);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  f[8]   = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd1};
        logic [31:0] a[8]   = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000,
                                32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB};
        logic [31:0] b[8]   = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h0, 32'h0, 32'h12345, 32'h0};
        logic [31:0] exp[8] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0,
                                32'hFFFFFFFF, 32'hFFFFFFFB, 32'h0, 32'h0};
        logic [31:0] res;
        int          lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bc);
            checks++;
            if (res !== exp[i]) begin
                failures++; $display("FAIL special[%0d] result: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != SpecLat) begin
                failures++;
                $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, SpecLat);
            end
            checks++;
            if (bc != SpecBusy) begin
                failures++;
                $display("FAIL special[%0d] busy cycles: got %0d expected %0d", i, bc, SpecBusy);
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        int          lat, bc, seen;
        run_op(3'd5, 32'd100, 32'd7, res, lat, bc);
        checks++;
        if (res !== 32'hE) begin
            failures++; $display("FAIL flush setup result: got %h expected e", res);
        end
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL flush busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL flush done: got %b expected 0", bus.done);
        end
        // New request straight after the abort.
        run_op(3'd4, 32'd1000, 32'd3, res, lat, bc);
        checks++;
        if (res !== 32'h14D) begin
            failures++; $display("FAIL post-flush result: got %h expected 14d", res);
        end
        checks++;
        if (lat != 33) begin
            failures++; $display("FAIL post-flush latency: got %0d expected 33", lat);
        end
        @(posedge clk);
        #1;
        // Flush aborting a run must leave result untouched; flush+start together drops start.
        issue(3'd5, 32'd200, 32'd9);
        repeat (31) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        issue(3'd5, 32'd200, 32'd9);
        bus.flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            seen += int'(bus.done) + int'(bus.busy);
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL flush activity: got %0d busy/done cycles expected 0", seen);
        end
        checks++;
        if (bus.result !== 32'h14D) begin
            failures++; $display("FAIL flush result kept: got %h expected 14d", bus.result);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int          lat, bc;
        run_op(3'd0, 32'd3, 32'd5, res, lat, bc);
        checks++;
        if (res !== 32'hF) begin
            failures++; $display("FAIL b2b first result: got %h expected f", res);
        end
        // Still in the DONE cycle: issue the next one.
        issue(3'd5, 32'd100, 32'd9);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL b2b no bubble: got busy %b expected 1", bus.busy);
        end
        wait_done(lat, bc);
        checks++;
        if (lat != 33) begin
            failures++; $display("FAIL b2b latency: got %0d expected 33", lat);
        end
        checks++;
        if (bus.result !== 32'hB) begin
            failures++; $display("FAIL b2b second result: got %h expected b", bus.result);
        end
        @(posedge clk);
        #1;
        // start held high (with changing operands) while busy is ignored.
        bus.funct3 = 3'd5;
        bus.op_a   = 32'd200;
        bus.op_b   = 32'd9;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd50;
        bus.op_b   = 32'd0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat != 13) begin
            failures++; $display("FAIL held start latency: got %0d expected 13", lat);
        end
        checks++;
        if (bus.result !== 32'h16) begin
            failures++; $display("FAIL held start result: got %h expected 16", bus.result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(3'd4, 32'd1000, 32'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL mid reset busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL mid reset done: got %b expected 0", bus.done);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            failures++; $display("FAIL mid reset result: got %h expected 0", bus.result);
        end
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            seen += int'(bus.done) + int'(bus.busy);
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL after reset activity: got %0d expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
